// File: rtl/alu_host_pkg.sv
// Shared definitions for the ALU byte-bus initiator: op codes, FSM states
// and the result-width helper.
package alu_host_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BEGIN = 3'd1,
    S_SEND1 = 3'd2,
    S_SEND2 = 3'd3,
    S_SEND3 = 3'd4,
    S_WAIT  = 3'd5,
    S_RESP  = 3'd6
  } state_e;

  // mul and div return a high byte ahead of the final byte
  function automatic logic two_byte_result(input logic [1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_watchdog.sv
// Loadable up-counter bounding the time spent waiting for the ALU end strobe.
module alu_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  import alu_host_pkg::*;

  localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Fires on the cycle whose increment brings the count to TIMEOUT_CYCLES
  assign expired_o = enable_i && (count_q == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/alu_host_driver.sv
// Initiator for the 8-bit sequential ALU: sends op/operands, collects the
// 1- or 2-byte result and returns it, aborting hung transactions.
module alu_host_driver #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_x,
  input  logic [7:0]  req_y,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_timeout,
  output logic [1:0]  alu_op,
  output logic        alu_begin,
  output logic [7:0]  alu_in,
  input  logic [7:0]  alu_out,
  input  logic        alu_end,
  output logic        alu_rst
);
  import alu_host_pkg::*;

  state_e      state_q, state_d;
  logic [15:0] x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [7:0]  hist_q, hist_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic [1:0]  alu_op_q, alu_op_d;
  logic        alu_begin_q, alu_begin_d;
  logic [7:0]  alu_in_q, alu_in_d;
  logic        alu_rst_q, alu_rst_d;
  logic        wd_clear, wd_enable, wd_expired;

  alu_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (wd_clear),
    .enable_i  (wd_enable),
    .expired_o (wd_expired)
  );

  // Outputs are registered: each *_d is the value for the next state's cycle
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    hist_d        = hist_q;
    req_ready_d   = req_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    alu_op_d      = alu_op_q;
    alu_begin_d   = 1'b0;
    alu_in_d      = '0;
    alu_rst_d     = 1'b0;
    wd_clear      = 1'b0;
    wd_enable     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          x_d         = req_x;
          y_d         = req_y;
          alu_op_d    = req_op;
          req_ready_d = 1'b0;
          alu_begin_d = 1'b1;
          state_d     = S_BEGIN;
        end
      end
      S_BEGIN: begin
        alu_in_d = y_q;
        state_d  = S_SEND1;
      end
      S_SEND1: begin
        alu_in_d = (alu_op_q == OP_DIV) ? x_q[15:8] : x_q[7:0];
        state_d  = S_SEND2;
      end
      S_SEND2: begin
        if (alu_op_q == OP_DIV) begin
          alu_in_d = x_q[7:0];
          state_d  = S_SEND3;
        end else begin
          hist_d   = '0;
          wd_clear = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_SEND3: begin
        hist_d   = '0;
        wd_clear = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        wd_enable = 1'b1;
        hist_d    = alu_out;
        // alu_end takes priority over a watchdog expiring in the same cycle
        if (alu_end) begin
          rsp_data_d    = two_byte_result(alu_op_q) ? {hist_q, alu_out}
                                                    : {8'h00, alu_out};
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = S_RESP;
        end else if (wd_expired) begin
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          alu_rst_d     = 1'b1;
          state_d       = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d   = 1'b0;
          rsp_timeout_d = 1'b0;
          req_ready_d   = 1'b1;
          state_d       = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      hist_q        <= '0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
      alu_op_q      <= '0;
      alu_begin_q   <= 1'b0;
      alu_in_q      <= '0;
      alu_rst_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hist_q        <= hist_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      alu_op_q      <= alu_op_d;
      alu_begin_q   <= alu_begin_d;
      alu_in_q      <= alu_in_d;
      alu_rst_q     <= alu_rst_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_timeout_q;
  assign alu_op      = alu_op_q;
  assign alu_begin   = alu_begin_q;
  assign alu_in      = alu_in_q;
  assign alu_rst     = alu_rst_q;

endmodule

// File: tb/tb_alu_host_driver.sv
// Directed plus randomized bench for alu_host_driver with a behavioural ALU
// that ends a chosen number of cycles after the last operand byte.
module tb_alu_host_driver;
  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_x;
  logic [7:0]  req_y;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_timeout;
  logic [1:0]  alu_op;
  logic        alu_begin;
  logic [7:0]  alu_in, alu_out;
  logic        alu_end, alu_rst;

  int checks = 0;
  int failures = 0;

  alu_host_driver #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_x(req_x), .req_y(req_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout),
    .alu_op(alu_op), .alu_begin(alu_begin), .alu_in(alu_in),
    .alu_out(alu_out), .alu_end(alu_end), .alu_rst(alu_rst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Arithmetic meaning of each op: add/sub 8-bit, mul signed 8x8, div {rem,quot}
  function automatic logic [15:0] ref_result(input logic [1:0] op, input logic [15:0] x,
                                             input logic [7:0] y);
    int a, b;
    int unsigned q, r;
    case (op)
      2'b00: return {8'h00, 8'(x[7:0] + y)};
      2'b01: return {8'h00, 8'(x[7:0] - y)};
      2'b10: begin
        a = int'($signed(x[7:0]));
        b = int'($signed(y));
        return 16'(a * b);
      end
      default: begin
        q = int'(x) / int'(y);
        r = int'(x) % int'(y);
        return {8'(r), 8'(q)};
      end
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 16'(req_ready), 16'd1);
    chk({tag, "_rsp_valid"}, 16'(rsp_valid), 16'd0);
    chk({tag, "_rsp_data"}, rsp_data, 16'h0000);
    chk({tag, "_rsp_timeout"}, 16'(rsp_timeout), 16'd0);
    chk({tag, "_alu_op"}, 16'(alu_op), 16'd0);
    chk({tag, "_alu_begin"}, 16'(alu_begin), 16'd0);
    chk({tag, "_alu_in"}, 16'(alu_in), 16'd0);
    chk({tag, "_alu_rst"}, 16'(alu_rst), 16'd0);
  endtask

  // lat = WAIT cycle (1-based) carrying alu_end; 0 = ALU never ends
  task automatic txn(input logic [1:0] op, input logic [15:0] x, input logic [7:0] y,
                     input int lat, input int hold);
    logic [7:0]  cap[3];
    logic [15:0] alu_res, exp;
    bit          two;
    int          n, limit;
    two = op[1];
    n = 0;
    while (!req_ready && n < 20) begin
      cyc();
      n++;
    end
    chk("req_ready_idle", 16'(req_ready), 16'd1);
    req_valid = 1'b1; req_op = op; req_x = x; req_y = y;
    alu_end = 1'($urandom_range(0, 1)); alu_out = 8'($urandom);
    cyc();
    req_x = 16'($urandom); req_y = 8'($urandom); req_op = 2'($urandom);
    chk("begin_pulse", 16'(alu_begin), 16'd1);
    chk("alu_op", 16'(alu_op), 16'(op));
    chk("in_begin", 16'(alu_in), 16'h0);
    chk("req_ready_busy", 16'(req_ready), 16'd0);
    cyc();
    cap[0] = alu_in;
    chk("send1", 16'(alu_in), 16'(y));
    chk("begin_one_cycle", 16'(alu_begin), 16'd0);
    cyc();
    cap[1] = alu_in;
    chk("send2", 16'(alu_in), 16'((op == 2'b11) ? x[15:8] : x[7:0]));
    cap[2] = 8'h00;
    if (op == 2'b11) begin
      cyc();
      cap[2] = alu_in;
      chk("send3", 16'(alu_in), 16'(x[7:0]));
    end
    req_valid = 1'b0;
    alu_end = 1'b0;
    alu_res = (op == 2'b11) ? ref_result(op, {cap[1], cap[2]}, cap[0])
                            : ref_result(op, {8'h00, cap[1]}, cap[0]);
    if (!two) alu_res[15:8] = 8'($urandom);
    if (lat == 0) exp = 16'h0000;
    else begin
      exp = ref_result(op, x, y);
      if (lat == 1) exp[15:8] = 8'h00;
    end
    limit = (lat == 0) ? TO : lat;
    for (int k = 1; k <= limit; k++) begin
      cyc();
      chk("wait_no_rsp", 16'(rsp_valid), 16'd0);
      chk("wait_in_zero", 16'(alu_in), 16'h0);
      alu_end = (lat != 0) && (k == lat);
      alu_out = (k == lat) ? alu_res[7:0] : ((k == lat - 1) ? alu_res[15:8] : 8'($urandom));
    end
    cyc();
    alu_end = 1'($urandom_range(0, 1));
    alu_out = 8'($urandom);
    req_valid = 1'b1;
    chk("rsp_valid", 16'(rsp_valid), 16'd1);
    chk("rsp_data", rsp_data, exp);
    chk("rsp_timeout", 16'(rsp_timeout), 16'(lat == 0));
    chk("alu_rst", 16'(alu_rst), 16'(lat == 0));
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 1'b0;
      cyc();
      chk("hold_valid", 16'(rsp_valid), 16'd1);
      chk("hold_data", rsp_data, exp);
      chk("hold_timeout", 16'(rsp_timeout), 16'(lat == 0));
      chk("hold_req_ready", 16'(req_ready), 16'd0);
      chk("hold_alu_rst", 16'(alu_rst), 16'd0);
    end
    req_valid = 1'b0;
    alu_end = 1'b0;
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    chk("idle_rsp_valid", 16'(rsp_valid), 16'd0);
    chk("idle_req_ready", 16'(req_ready), 16'd1);
    chk("idle_timeout", 16'(rsp_timeout), 16'd0);
    chk("idle_data_held", rsp_data, exp);
    chk("idle_alu_rst", 16'(alu_rst), 16'd0);
  endtask

  initial begin
    logic [1:0]  op;
    logic [7:0]  y;
    logic [15:0] x;
    rst = 1'b1;
    req_valid = 1'b0; req_op = '0; req_x = '0; req_y = '0;
    rsp_ready = 1'b0; alu_out = '0; alu_end = 1'b0;
    #1;
    check_reset_outputs("reset");
    #20;
    @(negedge clk);
    rst = 1'b0;

    txn(2'b00, 16'h0003, 8'h03, 3, 0);
    txn(2'b01, 16'h0007, 8'h02, 2, 5);
    txn(2'b10, 16'h0004, 8'hC5, 2, 1);
    txn(2'b11, 16'h127B, 8'h31, 3, 0);
    txn(2'b10, 16'h0055, 8'h7F, 0, 2);
    txn(2'b11, 16'h0A00, 8'h11, TO, 0);
    txn(2'b11, 16'h00FF, 8'h10, 1, 0);

    // abort mid-operation with a nonzero op and response data in flight
    req_valid = 1'b1; req_op = 2'b10; req_x = 16'h0012; req_y = 8'h34;
    cyc();
    req_valid = 1'b0;
    cyc();
    cyc();
    chk("pre_reset_send2", 16'(alu_in), 16'h0012);
    rst = 1'b1;
    #1;
    check_reset_outputs("midop_reset");
    @(negedge clk);
    rst = 1'b0;
    txn(2'b00, 16'h0021, 8'h15, 4, 1);

    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom);
      y = 8'($urandom);
      x = 16'($urandom);
      if (op == 2'b11) begin
        if (y == 8'h00) y = 8'h01;
        x[15:8] = 8'($urandom_range(0, int'(y) - 1));
      end
      txn(op, x, y, int'($urandom_range(1, 6)), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
